// File: rtl/alu_fp_pkg.sv
// Shared types and helpers for the sequential accumulator ALU with its
// sign|exponent|mantissa floating-point ADD path.
package alu_fp_pkg;

    localparam int DEF_EXP_W = 3;
    localparam int DEF_MAN_W = 4;

    localparam int BIAS    = (1 << (DEF_EXP_W - 1)) - 1;
    localparam int EXP_MAX = (1 << DEF_EXP_W) - 1;
    localparam int SIG_W   = DEF_MAN_W + 4;

    typedef enum logic [2:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_SUM   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    // Leading-one probe: is the significand bit at i_pos set?
    function automatic logic lead_one(input logic [31:0] i_vec, input int i_pos);
        return i_vec[i_pos];
    endfunction

endpackage

// File: rtl/alu_fp_round.sv
// Round-to-nearest-even on a hidden|mantissa|G|R|S significand, then saturate
// on exponent overflow and pack sign|exponent|mantissa.
module alu_fp_round
    import alu_fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic                    i_sign,
    input  logic signed [EXP_W+1:0] i_exp,
    input  logic [MAN_W+3:0]        i_sig,
    output logic [W-1:0]            o_res,
    output logic                    o_ovf
);
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] X_ONE  = XW'(1);
    localparam logic signed [XW-1:0] X_EMAX = XW'((1 << EXP_W) - 1);

    logic                 w_up;
    logic [MAN_W+1:0]     w_man_ext;
    logic [MAN_W-1:0]     w_man;
    logic signed [XW-1:0] w_exp;

    // Ties go to the even mantissa: round up only if G and (R|S|lsb).
    always_comb begin
        w_up      = lead_one(32'(i_sig), 2) & (i_sig[1] | i_sig[0] | i_sig[3]);
        w_man_ext = {1'b0, i_sig[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, w_up};
        if (w_man_ext[MAN_W+1]) begin
            w_man = w_man_ext[MAN_W:1];
            w_exp = i_exp + X_ONE;
        end else begin
            w_man = w_man_ext[MAN_W-1:0];
            w_exp = i_exp;
        end
        o_ovf = (w_exp > X_EMAX);
        if (o_ovf) begin
            o_res = {i_sign, {(W-1){1'b1}}};
        end else begin
            o_res = {i_sign, w_exp[EXP_W-1:0], w_man};
        end
    end

endmodule

// File: rtl/alu_fp_seq.sv
// Handshaked multi-cycle accumulator ALU: logic ops finish in one cycle, ADD is
// a float adder walking ALIGN -> SUM -> NORM* -> ROUND before DONE.
module alu_fp_seq
    import alu_fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   opcode,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] res,
    output logic         is_zero,
    output logic         ovf,
    output logic         unf
);
    localparam int SW = MAN_W + 4;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] X_ONE = XW'(1);

    state_e               r_state;
    state_e               w_state_nx;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic                 r_sign;
    logic                 r_sub;
    logic signed [XW-1:0] r_exp;
    logic [SW-1:0]        r_sig_a;
    logic [SW-1:0]        r_sig_b;
    logic [W-1:0]         r_res;
    logic                 r_zero;
    logic                 r_ovf;
    logic                 r_unf;
    logic                 r_out_valid;
    logic                 r_in_ready;

    logic [W-1:0]         w_logic_res;
    logic                 w_a_big;
    logic [W-1:0]         w_big;
    logic [W-1:0]         w_small;
    logic [EXP_W-1:0]     w_ediff;
    logic [SW-1:0]        w_small_sig;
    logic [SW-1:0]        w_small_sh;
    logic [SW-1:0]        w_aligned;
    logic                 w_sticky;
    logic [SW:0]          w_add;
    logic [SW-1:0]        w_sum;
    logic signed [XW-1:0] w_sum_exp;
    logic                 w_sum_zero;
    logic                 w_sum_norm;
    logic                 w_norm_unf;
    logic                 w_norm_last;
    logic [W-1:0]         w_rnd_res;
    logic                 w_rnd_ovf;

    // Single-cycle result for every opcode other than ADD.
    always_comb begin
        w_logic_res = inA;
        case (opcode_e'(opcode))
            OP_LDA:  w_logic_res = inB;
            OP_AND:  w_logic_res = inA & inB;
            OP_XOR:  w_logic_res = inA ^ inB;
            default: w_logic_res = inA;
        endcase
    end

    // Larger magnitude first; the smaller significand is shifted right and
    // everything shifted past the sticky position is ORed into it.
    always_comb begin
        w_a_big = (r_a[W-2:0] >= r_b[W-2:0]);
        if (w_a_big) begin
            w_big   = r_a;
            w_small = r_b;
        end else begin
            w_big   = r_b;
            w_small = r_a;
        end
        w_ediff     = w_big[W-2 -: EXP_W] - w_small[W-2 -: EXP_W];
        w_small_sig = {1'b1, w_small[MAN_W-1:0], 3'b000};
        w_small_sh  = w_small_sig >> w_ediff;
        w_sticky    = 1'b0;
        for (int i = 0; i < SW; i++) begin
            w_sticky = w_sticky | (w_small_sig[i] & (i < int'(w_ediff)));
        end
        w_aligned = {w_small_sh[SW-1:1], w_small_sh[0] | w_sticky};
    end

    // Magnitude add/subtract; a carry-out is folded back with the lost bit kept sticky.
    always_comb begin
        w_add     = {1'b0, r_sig_a} + {1'b0, r_sig_b};
        w_sum_exp = r_exp;
        if (r_sub) begin
            w_sum = r_sig_a - r_sig_b;
        end else if (w_add[SW]) begin
            w_sum     = {w_add[SW:2], w_add[1] | w_add[0]};
            w_sum_exp = r_exp + X_ONE;
        end else begin
            w_sum = w_add[SW-1:0];
        end
        w_sum_zero = (w_sum == '0);
        w_sum_norm = lead_one(32'(w_sum), SW - 1);
    end

    // The shift taken this cycle is the last one if the bit below hidden is already set.
    assign w_norm_unf  = (r_exp == '0);
    assign w_norm_last = lead_one(32'(r_sig_a), SW - 2);

    alu_fp_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .i_sign (r_sign),
        .i_exp  (r_exp),
        .i_sig  (r_sig_a),
        .o_res  (w_rnd_res),
        .o_ovf  (w_rnd_ovf)
    );

    // Next-state decode.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nx = (opcode_e'(opcode) == OP_ADD) ? S_ALIGN : S_DONE;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_ALIGN: w_state_nx = S_SUM;
            S_SUM: begin
                if (w_sum_zero) begin
                    w_state_nx = S_DONE;
                end else if (w_sum_norm) begin
                    w_state_nx = S_ROUND;
                end else begin
                    w_state_nx = S_NORM;
                end
            end
            S_NORM: begin
                if (w_norm_unf) begin
                    w_state_nx = S_DONE;
                end else if (w_norm_last) begin
                    w_state_nx = S_ROUND;
                end else begin
                    w_state_nx = S_NORM;
                end
            end
            S_ROUND: w_state_nx = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = S_DONE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Operand, working significand and result registers, advanced per state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sign  <= 1'b0;
            r_sub   <= 1'b0;
            r_exp   <= '0;
            r_sig_a <= '0;
            r_sig_b <= '0;
            r_res   <= '0;
            r_zero  <= 1'b1;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a <= inA;
                        r_b <= inB;
                        if (opcode_e'(opcode) != OP_ADD) begin
                            r_res  <= w_logic_res;
                            r_zero <= (w_logic_res == '0);
                            r_ovf  <= 1'b0;
                            r_unf  <= 1'b0;
                        end
                    end
                end
                S_ALIGN: begin
                    r_sig_a <= {1'b1, w_big[MAN_W-1:0], 3'b000};
                    r_sig_b <= w_aligned;
                    r_exp   <= $signed({2'b00, w_big[W-2 -: EXP_W]});
                    r_sign  <= w_big[W-1];
                    r_sub   <= w_big[W-1] ^ w_small[W-1];
                end
                S_SUM: begin
                    r_sig_a <= w_sum;
                    r_exp   <= w_sum_exp;
                    if (w_sum_zero) begin
                        r_res  <= '0;
                        r_zero <= 1'b1;
                        r_ovf  <= 1'b0;
                        r_unf  <= 1'b0;
                    end
                end
                S_NORM: begin
                    r_sig_a <= {r_sig_a[SW-2:0], 1'b0};
                    r_exp   <= r_exp - X_ONE;
                    if (w_norm_unf) begin
                        r_res  <= '0;
                        r_zero <= 1'b1;
                        r_ovf  <= 1'b0;
                        r_unf  <= 1'b1;
                    end
                end
                S_ROUND: begin
                    r_res  <= w_rnd_res;
                    r_zero <= (w_rnd_res == '0);
                    r_ovf  <= w_rnd_ovf;
                    r_unf  <= 1'b0;
                end
                default: begin
                    r_res <= r_res;
                end
            endcase
        end
    end

    // Handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_out_valid <= (w_state_nx == S_DONE);
            r_in_ready  <= (w_state_nx == S_IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign res       = r_res;
    assign is_zero   = r_zero;
    assign ovf       = r_ovf;
    assign unf       = r_unf;

endmodule
